regfile_arbiter: RTL and testbench

Sequences and shares the 64x16 dual-read/single-write RegisterFile between two requesters, e.g. the datapath core (requester 0) and a debug/DMA port (requester 1).
After reset it runs a clearing sweep that writes zero to every register, since the register file has no reset of its own.
In normal operation it grants one request per cycle using round-robin arbitration and returns registered read data one cycle after the grant.

---
 rtl/regfile_arbiter_pkg.sv | 31 +++
 rtl/regfile_arbiter_rr.sv | 30 +++
 rtl/regfile_arbiter.sv | 134 +++++++++++++
 tb/tb_regfile_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_arbiter_pkg.sv
// Shared types, constants and helpers for the register-file arbiter.
//   state_t       : sequencing state (clearing sweep vs normal operation)
//   NumRequesters : number of requesters sharing the register file
//   rr_next_grant : round-robin grant for two requesters
package regfile_arbiter_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int NumRequesters    = 2;
  localparam int DefAddressWidth  = 6;
  localparam int DefRegisterWidth = 16;

  // One-hot grant for two requesters. On a tie the requester that did not
  // win last time is chosen.
  function automatic logic [1:0] rr_next_grant(input logic [1:0] valid,
                                               input logic       last_grant);
    logic [1:0] grant;
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
    return grant;
  endfunction

endpackage

// File: rtl/regfile_arbiter_rr.sv
// Two-input round-robin arbiter.
//   Clock, ResetN : system clock, async active-low reset
//   Valid[1:0]    : request valid per requester
//   Enable        : grants are suppressed while low
//   Grant[1:0]    : one-hot (or zero) combinational grant
// The last winner is remembered so ties alternate; after reset requester 0
// wins the first tie.
module rr_arbiter2
  import regfile_arbiter_pkg::*;
(
  input  logic       Clock,
  input  logic       ResetN,
  input  logic [1:0] Valid,
  input  logic       Enable,
  output logic [1:0] Grant
);

  logic last_grant;

  assign Grant = Enable ? rr_next_grant(Valid, last_grant) : 2'b00;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      last_grant <= 1'b1;
    end else if (|Grant) begin
      last_grant <= Grant[1];
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Sequencer and arbiter in front of a 64x16 dual-read/single-write register
// file. After reset every register is cleared (the register file itself has
// no reset), then two requesters share it, one grant per cycle, round-robin.
//   Clock, ResetN          : system clock, async active-low reset
//   ReqValid/ReqReady      : per-requester handshake (ReqReady is the grant)
//   ReqWrite/ReqAddrA/B/WData : per-requester request fields, requester i in slice i
//   RespValid, RespDataA/B : one-cycle read response pulse and registered data
//   InitDone               : high once the clearing sweep is complete
//   Rf*                    : register file write/read port connections
//
// state | meaning
// INIT  | clearing sweep, writes zero to address InitCount, no grants
// RUN   | normal operation, round-robin grants, InitDone high
module regfile_arbiter
  import regfile_arbiter_pkg::*;
#(
  parameter int AddressWidth   = DefAddressWidth,
  parameter int RegisterHeight = 1 << AddressWidth,
  parameter int RegisterWidth  = DefRegisterWidth
) (
  input  logic                                   Clock,
  input  logic                                   ResetN,
  input  logic [NumRequesters-1:0]               ReqValid,
  output logic [NumRequesters-1:0]               ReqReady,
  input  logic [NumRequesters-1:0]               ReqWrite,
  input  logic [NumRequesters*AddressWidth-1:0]  ReqAddrA,
  input  logic [NumRequesters*AddressWidth-1:0]  ReqAddrB,
  input  logic [NumRequesters*RegisterWidth-1:0] ReqWData,
  output logic [NumRequesters-1:0]               RespValid,
  output logic [RegisterWidth-1:0]               RespDataA,
  output logic [RegisterWidth-1:0]               RespDataB,
  output logic                                   InitDone,
  output logic                                   RfWriteEnable,
  output logic [RegisterWidth-1:0]               RfWriteData,
  output logic [AddressWidth-1:0]                RfAddressA,
  output logic [AddressWidth-1:0]                RfAddressB,
  input  logic [RegisterWidth-1:0]               RfReadDataA,
  input  logic [RegisterWidth-1:0]               RfReadDataB
);

  state_t                     state;
  logic [AddressWidth-1:0]    init_count;
  logic [NumRequesters-1:0]   grant;
  logic                       run;
  logic                       sel;
  logic                       sel_write;
  logic [AddressWidth-1:0]    sel_addr_a;
  logic [AddressWidth-1:0]    sel_addr_b;
  logic [RegisterWidth-1:0]   sel_wdata;
  logic                       read_grant;

  assign run = (state == RUN);

  rr_arbiter2 u_arb (
    .Clock  (Clock),
    .ResetN (ResetN),
    .Valid  (ReqValid),
    .Enable (run),
    .Grant  (grant)
  );

  assign ReqReady = grant;

  // Grant is one-hot, so the upper bit alone selects the winning slice.
  assign sel        = grant[1];
  assign sel_write  = sel ? ReqWrite[1] : ReqWrite[0];
  assign sel_addr_a = sel ? ReqAddrA[2*AddressWidth-1:AddressWidth]
                          : ReqAddrA[AddressWidth-1:0];
  assign sel_addr_b = sel ? ReqAddrB[2*AddressWidth-1:AddressWidth]
                          : ReqAddrB[AddressWidth-1:0];
  assign sel_wdata  = sel ? ReqWData[2*RegisterWidth-1:RegisterWidth]
                          : ReqWData[RegisterWidth-1:0];
  assign read_grant = (|grant) & ~sel_write;

  always_comb begin
    RfWriteEnable = 1'b0;
    RfWriteData   = '0;
    RfAddressA    = '0;
    RfAddressB    = '0;
    if (state == INIT) begin
      RfWriteEnable = 1'b1;
      RfAddressA    = init_count;
    end else if (|grant) begin
      RfAddressA = sel_addr_a;
      if (sel_write) begin
        RfWriteEnable = 1'b1;
        RfWriteData   = sel_wdata;
      end else begin
        RfAddressB = sel_addr_b;
      end
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state      <= INIT;
      init_count <= '0;
      InitDone   <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          init_count <= init_count + 1'b1;
          if (init_count == AddressWidth'(RegisterHeight - 1)) begin
            state    <= RUN;
            InitDone <= 1'b1;
          end
        end
        RUN: begin
          InitDone <= 1'b1;
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

  // Register file reads are combinational, so data is captured at the grant
  // edge and presented for exactly one cycle; data holds afterwards.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      RespValid <= '0;
      RespDataA <= '0;
      RespDataB <= '0;
    end else if (read_grant) begin
      RespValid <= grant;
      RespDataA <= RfReadDataA;
      RespDataB <= RfReadDataB;
    end else begin
      RespValid <= '0;
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
module tb_regfile_arbiter;
  localparam int AW = 6;
  localparam int RW = 16;
  localparam int RH = 64;

  logic          Clock;
  logic          ResetN;
  logic [1:0]    ReqValid;
  logic [1:0]    ReqReady;
  logic [1:0]    ReqWrite;
  logic [2*AW-1:0] ReqAddrA;
  logic [2*AW-1:0] ReqAddrB;
  logic [2*RW-1:0] ReqWData;
  logic [1:0]    RespValid;
  logic [RW-1:0] RespDataA;
  logic [RW-1:0] RespDataB;
  logic          InitDone;
  logic          RfWriteEnable;
  logic [RW-1:0] RfWriteData;
  logic [AW-1:0] RfAddressA;
  logic [AW-1:0] RfAddressB;
  logic [RW-1:0] RfReadDataA;
  logic [RW-1:0] RfReadDataB;

  int total = 0;
  int bad = 0;

  regfile_arbiter dut (
    .Clock(Clock), .ResetN(ResetN), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqWrite(ReqWrite), .ReqAddrA(ReqAddrA), .ReqAddrB(ReqAddrB), .ReqWData(ReqWData),
    .RespValid(RespValid), .RespDataA(RespDataA), .RespDataB(RespDataB),
    .InitDone(InitDone), .RfWriteEnable(RfWriteEnable), .RfWriteData(RfWriteData),
    .RfAddressA(RfAddressA), .RfAddressB(RfAddressB),
    .RfReadDataA(RfReadDataA), .RfReadDataB(RfReadDataB)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Register file environment: no reset, pre-filled with all ones.
  logic [RW-1:0] rf_mem [RH];
  initial for (int i = 0; i < RH; i++) rf_mem[i] = 16'hFFFF;
  always @(posedge Clock) if (RfWriteEnable) rf_mem[RfAddressA] <= RfWriteData;
  assign RfReadDataA = rf_mem[RfAddressA];
  assign RfReadDataB = rf_mem[RfAddressB];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: sweep length, round-robin fairness, expected contents.
  int            m_init_left;
  logic          m_last;
  logic [1:0]    m_rv;
  logic [RW-1:0] m_ra, m_rb;
  logic          m_done;
  logic [RW-1:0] m_mem [RH];
  logic [1:0]    e_g;
  int            gi;
  logic [AW-1:0] aa, ab;
  logic [RW-1:0] wd;

  always @(negedge Clock) begin
    if (!ResetN) begin
      m_init_left = RH; m_last = 1'b1; m_rv = 2'b00; m_ra = '0; m_rb = '0; m_done = 1'b0;
      for (int i = 0; i < RH; i++) m_mem[i] = '0;
      chk("rst_resp_valid", 32'(RespValid), 0);
      chk("rst_resp_a", 32'(RespDataA), 0);
      chk("rst_resp_b", 32'(RespDataB), 0);
      chk("rst_init_done", 32'(InitDone), 0);
      chk("rst_ready", 32'(ReqReady), 0);
    end else begin
      chk("resp_valid", 32'(RespValid), 32'(m_rv));
      chk("resp_a", 32'(RespDataA), 32'(m_ra));
      chk("resp_b", 32'(RespDataB), 32'(m_rb));
      chk("init_done", 32'(InitDone), 32'(m_done));
      e_g = 2'b00;
      if (m_init_left == 0) begin
        if (ReqValid == 2'b01) e_g = 2'b01;
        else if (ReqValid == 2'b10) e_g = 2'b10;
        else if (ReqValid == 2'b11) e_g = m_last ? 2'b01 : 2'b10;
      end
      chk("ready", 32'(ReqReady), 32'(e_g));
      if (m_init_left > 0) begin
        chk("init_we", 32'(RfWriteEnable), 1);
        chk("init_addr_a", 32'(RfAddressA), 32'(RH - m_init_left));
        chk("init_wdata", 32'(RfWriteData), 0);
        chk("init_addr_b", 32'(RfAddressB), 0);
        m_init_left--;
        if (m_init_left == 0) m_done = 1'b1;
        m_rv = 2'b00;
      end else if (e_g == 2'b00) begin
        chk("idle_we", 32'(RfWriteEnable), 0);
        chk("idle_addr_a", 32'(RfAddressA), 0);
        chk("idle_addr_b", 32'(RfAddressB), 0);
        m_rv = 2'b00;
      end else begin
        gi = e_g[1] ? 1 : 0;
        aa = ReqAddrA[gi*AW +: AW];
        ab = ReqAddrB[gi*AW +: AW];
        wd = ReqWData[gi*RW +: RW];
        m_last = e_g[1];
        if (ReqWrite[gi]) begin
          chk("wr_we", 32'(RfWriteEnable), 1);
          chk("wr_addr", 32'(RfAddressA), 32'(aa));
          chk("wr_data", 32'(RfWriteData), 32'(wd));
          m_mem[aa] = wd;
          m_rv = 2'b00;
        end else begin
          chk("rd_we", 32'(RfWriteEnable), 0);
          chk("rd_addr_a", 32'(RfAddressA), 32'(aa));
          chk("rd_addr_b", 32'(RfAddressB), 32'(ab));
          m_rv = e_g;
          m_ra = m_mem[aa];
          m_rb = m_mem[ab];
        end
      end
    end
  end

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_req(input int r, input logic wr, input logic [AW-1:0] a,
                         input logic [AW-1:0] b, input logic [RW-1:0] d);
    ReqWrite[r] = wr;
    ReqAddrA[r*AW +: AW] = a;
    ReqAddrB[r*AW +: AW] = b;
    ReqWData[r*RW +: RW] = d;
  endtask

  task automatic wait_init(input string nm);
    int n;
    n = 0;
    while (!InitDone && n < 200) begin cyc(); n++; end
    chk(nm, 32'(n), 64);
  endtask

  initial begin
    int n;
    logic [1:0] got [6];
    ResetN = 1'b0; ReqValid = '0; ReqWrite = '0; ReqAddrA = '0; ReqAddrB = '0; ReqWData = '0;
    cyc(); cyc();
    ResetN = 1'b1;

    // 1: sweep length, then every register reads zero
    wait_init("init_cycles");
    for (int i = 0; i < RH; i += 2) begin
      ReqValid = 2'b01; set_req(0, 1'b0, AW'(i), AW'(i + 1), '0);
      cyc();
    end
    ReqValid = 2'b00;
    cyc();

    // 2: write then read-after-write
    ReqValid = 2'b01; set_req(0, 1'b1, 6'd12, 6'd0, 16'h1234);
    cyc();
    set_req(0, 1'b0, 6'd12, 6'd21, '0);
    cyc();
    ReqValid = 2'b00;
    chk("raw_valid", 32'(RespValid), 32'h1);
    chk("raw_a", 32'(RespDataA), 32'h1234);
    chk("raw_b", 32'(RespDataB), 32'h0);
    cyc();

    // requester 1 transfer leaves LastGrant = 1 for the tie tests
    ReqValid = 2'b10; set_req(1, 1'b0, 6'd3, 6'd4, '0);
    cyc();
    ReqValid = 2'b00;
    cyc();

    // 3: both requesters reading for six cycles alternate 0,1,0,1,0,1
    for (int i = 0; i < 6; i++) begin
      ReqValid = 2'b11;
      set_req(0, 1'b0, AW'($urandom_range(0, 63)), AW'($urandom_range(0, 63)), '0);
      set_req(1, 1'b0, AW'($urandom_range(0, 63)), AW'($urandom_range(0, 63)), '0);
      @(negedge Clock);
      got[i] = ReqReady;
      cyc();
    end
    ReqValid = 2'b00;
    for (int i = 0; i < 6; i++) chk("tie_order", 32'(got[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
    cyc();

    // 4: simultaneous read (req 0) and write (req 1) to address 21
    ReqValid = 2'b11;
    set_req(0, 1'b0, 6'd21, 6'd21, '0);
    set_req(1, 1'b1, 6'd21, 6'd0, 16'hABCD);
    cyc();
    ReqValid = 2'b10;
    chk("conflict_valid", 32'(RespValid), 32'h1);
    chk("conflict_a", 32'(RespDataA), 32'h0);
    cyc();
    ReqValid = 2'b01;
    cyc();
    ReqValid = 2'b00;
    chk("reread_valid", 32'(RespValid), 32'h1);
    chk("reread_a", 32'(RespDataA), 32'hABCD);
    cyc();

    // random traffic checked by the model
    for (int i = 0; i < 400; i++) begin
      ReqValid = 2'($urandom_range(0, 3));
      for (int r = 0; r < 2; r++)
        set_req(r, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)),
                AW'($urandom_range(0, 63)), RW'($urandom));
      cyc();
    end
    ReqValid = 2'b00;
    cyc();

    // 5: reset in the middle of the sweep restarts it from address 0
    ResetN = 1'b0; cyc(); ResetN = 1'b1;
    for (int i = 0; i < 30; i++) cyc();
    chk("mid_init_done", 32'(InitDone), 0);
    chk("mid_addr", 32'(RfAddressA), 30);
    ResetN = 1'b0; cyc(); ResetN = 1'b1;
    wait_init("restart_cycles");
    cyc();

    // 6: request held across the sweep is accepted in the first RUN cycle
    ResetN = 1'b0;
    ReqValid = 2'b10; set_req(1, 1'b1, 6'd63, 6'd0, 16'h5A5A);
    cyc();
    ResetN = 1'b1;
    n = 0;
    while (!ReqReady[1] && n < 200) begin cyc(); n++; end
    chk("held_wait", 32'(n), 64);
    cyc();
    set_req(1, 1'b0, 6'd63, 6'd63, '0);
    cyc();
    ReqValid = 2'b00;
    chk("held_valid", 32'(RespValid), 32'h2);
    chk("held_a", 32'(RespDataA), 32'h5A5A);
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
